// File: rtl/mips_pkg.sv
// Shared definitions for the ID-stage jump controller.
// Holds the opcode/funct codes, the link register index, the FSM state
// encoding and a small decode helper for register-indirect jumps.
package mips_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    // SPECIAL funct codes (instruction[5:0])
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // Link register used by JAL (and JALR when the jump unit selects it)
    localparam int LINK_REG_IDX = 31;

    // Jump controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_REDIRECT = 2'd2
    } jump_state_t;

    // True for JR/JALR: the only jumps that read rs and can hazard
    function automatic logic is_reg_jump(input logic [5:0] opcode,
                                         input logic [5:0] funct);
        return (opcode == OP_SPECIAL) && ((funct == FN_JR) || (funct == FN_JALR));
    endfunction

endpackage : mips_pkg

// File: rtl/jump_hazard_detect.sv
// Combinational read-after-write hazard check for a source register read
// in ID. Flags a conflict with a register write in EX or a load in MEM.
// r0 never hazards. Kept separate so a branch controller can reuse it.
module jump_hazard_detect #(
    parameter int REG_ADDR = 5
) (
    input  logic                i_check_en,
    input  logic [REG_ADDR-1:0] i_rs,
    input  logic                i_ex_regwrite,
    input  logic [REG_ADDR-1:0] i_ex_rd,
    input  logic                i_mem_memread,
    input  logic [REG_ADDR-1:0] i_mem_rd,
    output logic                o_hazard
);

    logic w_rs_nonzero;
    logic w_ex_match;
    logic w_mem_match;

    assign w_rs_nonzero = (i_rs != '0);
    assign w_ex_match   = i_ex_regwrite && (i_ex_rd == i_rs);
    assign w_mem_match  = i_mem_memread && (i_mem_rd == i_rs);

    // Hazard only when the instruction actually reads rs and rs is live
    assign o_hazard = i_check_en && w_rs_nonzero && (w_ex_match || w_mem_match);

endmodule : jump_hazard_detect

// File: rtl/jump_ctrl.sv
// ID-stage jump sequencer (J, JAL, JR, JALR).
// Stalls JR/JALR while rs is being produced by EX or loaded in MEM,
// then issues a single-cycle PC redirect with IF/ID and ID/EX flushes and
// the link-register write strobe.
// Optional build macro: JUMP_CTRL_STATS_EN adds redirect/stall counters.
module jump_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5,
    parameter int MAX_WAIT   = 4,
    parameter int SIZEOP     = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_hold,
    input  logic                  i_valid_id,
    input  logic [DATA_WIDTH-1:0] i_instruccion,
    input  logic                  i_jump,
    input  logic                  i_return,
    input  logic                  i_rd_selector,
    input  logic [DATA_WIDTH-1:0] i_pcjump,
    input  logic [DATA_WIDTH-1:0] i_return_address,
    input  logic                  i_ex_regwrite,
    input  logic [REG_ADDR-1:0]   i_ex_rd,
    input  logic                  i_mem_memread,
    input  logic [REG_ADDR-1:0]   i_mem_rd,
    output logic                  o_pc_sel,
    output logic [DATA_WIDTH-1:0] o_pc_target,
    output logic                  o_stall,
    output logic                  o_flush_ifid,
    output logic                  o_flush_idex,
    output logic                  o_link_we,
    output logic [REG_ADDR-1:0]   o_link_addr,
    output logic [DATA_WIDTH-1:0] o_link_data,
    output logic                  o_timeout
`ifdef JUMP_CTRL_STATS_EN
    ,
    output logic [31:0]           o_jump_count,
    output logic [31:0]           o_stall_count
`endif
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    jump_state_t           r_state;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_link_pend;
    logic                  r_timeout;
    logic [DATA_WIDTH-1:0] r_pc_target;
    logic [DATA_WIDTH-1:0] r_link_data;
    logic [REG_ADDR-1:0]   r_link_addr;

    logic [SIZEOP-1:0]     w_opcode;
    logic [SIZEOP-1:0]     w_funct;
    logic [REG_ADDR-1:0]   w_rs;
    logic [REG_ADDR-1:0]   w_rd;
    logic                  w_reg_jump;
    logic                  w_hazard;
    logic                  w_at_limit;
    logic                  w_take_idle;
    logic                  w_leave_wait;
    logic                  w_capture;
    logic                  w_in_redirect;
    logic                  w_unused;

    // Instruction field decode
    assign w_opcode   = i_instruccion[31 -: SIZEOP];
    assign w_funct    = i_instruccion[SIZEOP-1:0];
    assign w_rs       = i_instruccion[21 +: REG_ADDR];
    assign w_rd       = i_instruccion[11 +: REG_ADDR];
    assign w_reg_jump = is_reg_jump(w_opcode, w_funct);
    assign w_unused   = ^{i_instruccion[20:16], i_instruccion[10:6]};

    jump_hazard_detect #(
        .REG_ADDR (REG_ADDR)
    ) u_hazard (
        .i_check_en    (w_reg_jump),
        .i_rs          (w_rs),
        .i_ex_regwrite (i_ex_regwrite),
        .i_ex_rd       (i_ex_rd),
        .i_mem_memread (i_mem_memread),
        .i_mem_rd      (i_mem_rd),
        .o_hazard      (w_hazard)
    );

    // A stalled jump gives up waiting once the counter reaches MAX_WAIT
    assign w_at_limit   = (r_wait_cnt == CNT_W'(MAX_WAIT));
    assign w_take_idle  = (r_state == ST_IDLE) && i_valid_id && i_jump && !w_hazard;
    assign w_leave_wait = (r_state == ST_WAIT) && (!w_hazard || w_at_limit);
    assign w_capture    = !i_hold && (w_take_idle || w_leave_wait);

    // Sequencing FSM: IDLE -> (WAIT) -> REDIRECT -> IDLE, frozen while held
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (!i_hold) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid_id && i_jump) begin
                        if (w_hazard) begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= CNT_W'(1);
                        end else begin
                            r_state    <= ST_REDIRECT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!w_hazard) begin
                        r_state    <= ST_REDIRECT;
                        r_wait_cnt <= '0;
                    end else if (w_at_limit) begin
                        r_state    <= ST_REDIRECT;
                        r_wait_cnt <= '0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                ST_REDIRECT: begin
                    // ID holds a wrong-path instruction here; never sample it
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Capture jump target and link information on the cycle the jump is accepted
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc_target <= '0;
            r_link_data <= '0;
            r_link_addr <= '0;
            r_link_pend <= 1'b0;
        end else if (w_capture) begin
            r_pc_target <= i_pcjump;
            r_link_data <= i_return_address;
            r_link_addr <= i_rd_selector ? REG_ADDR'(LINK_REG_IDX) : w_rd;
            r_link_pend <= i_return;
        end
    end

    // Redirect pulses come from the state register and are masked by hold
    assign w_in_redirect = (r_state == ST_REDIRECT) && !i_hold;
    assign o_pc_sel      = w_in_redirect;
    assign o_flush_ifid  = w_in_redirect;
    assign o_flush_idex  = w_in_redirect;
    assign o_link_we     = w_in_redirect && r_link_pend;
    assign o_stall       = (r_state == ST_WAIT);
    assign o_pc_target   = r_pc_target;
    assign o_link_addr   = r_link_addr;
    assign o_link_data   = r_link_data;
    assign o_timeout     = r_timeout;

`ifdef JUMP_CTRL_STATS_EN
    logic [31:0] r_jump_count;
    logic [31:0] r_stall_count;

    // Free-running event counters for redirects and hazard-wait cycles
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_jump_count  <= '0;
            r_stall_count <= '0;
        end else if (!i_hold) begin
            if (r_state == ST_REDIRECT) begin
                r_jump_count <= r_jump_count + 32'd1;
            end
            if (r_state == ST_WAIT) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign o_jump_count  = r_jump_count;
    assign o_stall_count = r_stall_count;
`endif

endmodule : jump_ctrl

// File: tb/tb_jump_ctrl.sv
// Directed self-checking bench for jump_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_jump_ctrl;

    logic        clk;
    logic        i_reset;
    logic        i_hold;
    logic        i_valid_id;
    logic [31:0] i_instruccion;
    logic        i_jump;
    logic        i_return;
    logic        i_rd_selector;
    logic [31:0] i_pcjump;
    logic [31:0] i_return_address;
    logic        i_ex_regwrite;
    logic [4:0]  i_ex_rd;
    logic        i_mem_memread;
    logic [4:0]  i_mem_rd;
    logic        o_pc_sel;
    logic [31:0] o_pc_target;
    logic        o_stall;
    logic        o_flush_ifid;
    logic        o_flush_idex;
    logic        o_link_we;
    logic [4:0]  o_link_addr;
    logic [31:0] o_link_data;
    logic        o_timeout;
`ifdef JUMP_CTRL_STATS_EN
    logic [31:0] o_jump_count;
    logic [31:0] o_stall_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    jump_ctrl #(
        .DATA_WIDTH (32),
        .REG_ADDR   (5),
        .MAX_WAIT   (4),
        .SIZEOP     (6)
    ) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_hold           (i_hold),
        .i_valid_id       (i_valid_id),
        .i_instruccion    (i_instruccion),
        .i_jump           (i_jump),
        .i_return         (i_return),
        .i_rd_selector    (i_rd_selector),
        .i_pcjump         (i_pcjump),
        .i_return_address (i_return_address),
        .i_ex_regwrite    (i_ex_regwrite),
        .i_ex_rd          (i_ex_rd),
        .i_mem_memread    (i_mem_memread),
        .i_mem_rd         (i_mem_rd),
        .o_pc_sel         (o_pc_sel),
        .o_pc_target      (o_pc_target),
        .o_stall          (o_stall),
        .o_flush_ifid     (o_flush_ifid),
        .o_flush_idex     (o_flush_idex),
        .o_link_we        (o_link_we),
        .o_link_addr      (o_link_addr),
        .o_link_data      (o_link_data),
        .o_timeout        (o_timeout)
`ifdef JUMP_CTRL_STATS_EN
        ,
        .o_jump_count     (o_jump_count),
        .o_stall_count    (o_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse vector: {pc_sel, stall, flush_ifid, flush_idex, link_we}
    function automatic logic [4:0] pulses();
        return {o_pc_sel, o_stall, o_flush_ifid, o_flush_idex, o_link_we};
    endfunction

    task automatic drive_id(input logic v, input logic j, input logic ret,
                            input logic rsel, input logic [31:0] instr,
                            input logic [31:0] tgt, input logic [31:0] ra);
        i_valid_id       = v;
        i_jump           = j;
        i_return         = ret;
        i_rd_selector    = rsel;
        i_instruccion    = instr;
        i_pcjump         = tgt;
        i_return_address = ra;
    endtask

    task automatic clear_id();
        drive_id(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        #12;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL reset_pulses got=%b exp=%b", pulses(), 5'b00000); end
        n_cmp++; if (o_pc_target !== 32'h0) begin n_err++; $display("FAIL reset_target got=%h exp=%h", o_pc_target, 32'h0); end
        n_cmp++; if (o_link_addr !== 5'd0) begin n_err++; $display("FAIL reset_link_addr got=%0d exp=0", o_link_addr); end
        n_cmp++; if (o_link_data !== 32'h0) begin n_err++; $display("FAIL reset_link_data got=%h exp=0", o_link_data); end
        n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got=%b exp=0", o_timeout); end
        @(negedge clk);
        i_reset = 1'b1;
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_j();
        @(negedge clk); drive_id(1, 1, 0, 0, 32'h0800_0040, 32'h0000_0100, 32'h44); #1;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL j_cycleN got=%b exp=%b", pulses(), 5'b00000); end
        @(negedge clk); clear_id(); #1;
        n_cmp++; if (pulses() !== 5'b10110) begin n_err++; $display("FAIL j_redirect got=%b exp=%b", pulses(), 5'b10110); end
        n_cmp++; if (o_pc_target !== 32'h100) begin n_err++; $display("FAIL j_target got=%h exp=%h", o_pc_target, 32'h100); end
        @(negedge clk); #1;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL j_after got=%b exp=%b", pulses(), 5'b00000); end
        $display("test_j: J target 0x100");
    endtask

    task automatic test_jal();
        @(negedge clk); drive_id(1, 1, 1, 1, 32'h0C00_0000, 32'h0000_0180, 32'h42); #1;
        @(negedge clk); clear_id(); #1;
        n_cmp++; if (pulses() !== 5'b10111) begin n_err++; $display("FAIL jal_redirect got=%b exp=%b", pulses(), 5'b10111); end
        n_cmp++; if (o_link_addr !== 5'd31) begin n_err++; $display("FAIL jal_link_addr got=%0d exp=31", o_link_addr); end
        n_cmp++; if (o_link_data !== 32'h42) begin n_err++; $display("FAIL jal_link_data got=%h exp=%h", o_link_data, 32'h42); end
        @(negedge clk); #1;
        $display("test_jal: link r31 <= 0x42");
    endtask

    task automatic test_jalr_hazard();
        // JALR rs=5 rd=7, EX writes r5 for one cycle
        @(negedge clk); drive_id(1, 1, 1, 0, 32'h00A0_3809, 32'h0000_0200, 32'h48);
        i_ex_regwrite = 1'b1; i_ex_rd = 5'd5; #1;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL jalr_cycleN got=%b exp=%b", pulses(), 5'b00000); end
        @(negedge clk); i_ex_regwrite = 1'b0; i_pcjump = 32'h0000_0300; #1;
        n_cmp++; if (pulses() !== 5'b01000) begin n_err++; $display("FAIL jalr_stall got=%b exp=%b", pulses(), 5'b01000); end
        @(negedge clk); clear_id(); #1;
        n_cmp++; if (pulses() !== 5'b10111) begin n_err++; $display("FAIL jalr_redirect got=%b exp=%b", pulses(), 5'b10111); end
        n_cmp++; if (o_pc_target !== 32'h300) begin n_err++; $display("FAIL jalr_target got=%h exp=%h", o_pc_target, 32'h300); end
        n_cmp++; if (o_link_addr !== 5'd7) begin n_err++; $display("FAIL jalr_link_addr got=%0d exp=7", o_link_addr); end
        @(negedge clk); #1;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL jalr_after got=%b exp=%b", pulses(), 5'b00000); end
        $display("test_jalr_hazard: one stall, link r7, target 0x300");
    endtask

    task automatic test_jr_timeout();
        // JR rs=3 against a MEM load to r3 that never clears
        @(negedge clk); drive_id(1, 1, 0, 0, 32'h0060_0008, 32'h0000_0400, 32'h0);
        i_mem_memread = 1'b1; i_mem_rd = 5'd3; #1;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL jr_cycleN got=%b exp=%b", pulses(), 5'b00000); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (pulses() !== 5'b01000) begin n_err++; $display("FAIL jr_stall%0d got=%b exp=%b", k, pulses(), 5'b01000); end
            n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL jr_timeout_early%0d got=%b exp=0", k, o_timeout); end
        end
        @(negedge clk); i_mem_memread = 1'b0; clear_id(); #1;
        n_cmp++; if (pulses() !== 5'b10110) begin n_err++; $display("FAIL jr_redirect got=%b exp=%b", pulses(), 5'b10110); end
        n_cmp++; if (o_timeout !== 1'b1) begin n_err++; $display("FAIL jr_timeout got=%b exp=1", o_timeout); end
        n_cmp++; if (o_pc_target !== 32'h400) begin n_err++; $display("FAIL jr_target got=%h exp=%h", o_pc_target, 32'h400); end
        @(negedge clk); #1;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL jr_after got=%b exp=%b", pulses(), 5'b00000); end
        n_cmp++; if (o_timeout !== 1'b1) begin n_err++; $display("FAIL jr_timeout_sticky got=%b exp=1", o_timeout); end
        $display("test_jr_timeout: 4 stall cycles then forced redirect");
    endtask

    task automatic test_rs_zero();
        // JR r0 with EX and MEM both naming r0: no stall
        @(negedge clk); drive_id(1, 1, 0, 0, 32'h0000_0008, 32'h0000_0480, 32'h0);
        i_ex_regwrite = 1'b1; i_ex_rd = 5'd0; i_mem_memread = 1'b1; i_mem_rd = 5'd0; #1;
        @(negedge clk); clear_id(); i_ex_regwrite = 1'b0; i_mem_memread = 1'b0; #1;
        n_cmp++; if (pulses() !== 5'b10110) begin n_err++; $display("FAIL rs0_redirect got=%b exp=%b", pulses(), 5'b10110); end
        n_cmp++; if (o_pc_target !== 32'h480) begin n_err++; $display("FAIL rs0_target got=%h exp=%h", o_pc_target, 32'h480); end
        @(negedge clk); #1;
        $display("test_rs_zero: JR r0 redirects without stall");
    endtask

    task automatic test_hold();
        @(negedge clk); drive_id(1, 1, 1, 1, 32'h0C00_0010, 32'h0000_0500, 32'h88); #1;
        @(negedge clk); clear_id(); i_hold = 1'b1; #1;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL hold_c0 got=%b exp=%b", pulses(), 5'b00000); end
        for (int k = 1; k < 3; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL hold_c%0d got=%b exp=%b", k, pulses(), 5'b00000); end
        end
        @(negedge clk); i_hold = 1'b0; #1;
        n_cmp++; if (pulses() !== 5'b10111) begin n_err++; $display("FAIL hold_release got=%b exp=%b", pulses(), 5'b10111); end
        n_cmp++; if (o_pc_target !== 32'h500) begin n_err++; $display("FAIL hold_target got=%h exp=%h", o_pc_target, 32'h500); end
        n_cmp++; if (o_link_data !== 32'h88) begin n_err++; $display("FAIL hold_link_data got=%h exp=%h", o_link_data, 32'h88); end
        @(negedge clk); #1;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL hold_after got=%b exp=%b", pulses(), 5'b00000); end
        $display("test_hold: redirect frozen 3 cycles, single pulse after release");
    endtask

    task automatic test_back_to_back();
        // A second jump visible during REDIRECT is wrong-path and must be dropped
        @(negedge clk); drive_id(1, 1, 0, 0, 32'h0800_0000, 32'h0000_0600, 32'h0); #1;
        @(negedge clk); drive_id(1, 1, 0, 0, 32'h0800_0001, 32'h0000_0700, 32'h0); #1;
        n_cmp++; if (pulses() !== 5'b10110) begin n_err++; $display("FAIL b2b_redirect got=%b exp=%b", pulses(), 5'b10110); end
        @(negedge clk); clear_id(); #1;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL b2b_ignored got=%b exp=%b", pulses(), 5'b00000); end
        n_cmp++; if (o_pc_target !== 32'h600) begin n_err++; $display("FAIL b2b_target got=%h exp=%h", o_pc_target, 32'h600); end
        @(negedge clk); #1;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL b2b_after got=%b exp=%b", pulses(), 5'b00000); end
        $display("test_back_to_back: jump in REDIRECT cycle ignored");
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk); drive_id(1, 1, 0, 0, 32'h0060_0008, 32'h0000_0700, 32'h0);
        i_mem_memread = 1'b1; i_mem_rd = 5'd3; #1;
        @(negedge clk); #1;
        n_cmp++; if (pulses() !== 5'b01000) begin n_err++; $display("FAIL rst_wait_stall got=%b exp=%b", pulses(), 5'b01000); end
        @(negedge clk); i_reset = 1'b0; #1;
        n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL rst_mid_pulses got=%b exp=%b", pulses(), 5'b00000); end
        n_cmp++; if (o_pc_target !== 32'h0) begin n_err++; $display("FAIL rst_mid_target got=%h exp=0", o_pc_target); end
        n_cmp++; if (o_link_addr !== 5'd0) begin n_err++; $display("FAIL rst_mid_link_addr got=%0d exp=0", o_link_addr); end
        n_cmp++; if (o_link_data !== 32'h0) begin n_err++; $display("FAIL rst_mid_link_data got=%h exp=0", o_link_data); end
        n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL rst_mid_timeout got=%b exp=0", o_timeout); end
        @(negedge clk); i_reset = 1'b1; i_mem_memread = 1'b0; clear_id(); #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (pulses() !== 5'b00000) begin n_err++; $display("FAIL rst_no_redirect%0d got=%b exp=%b", k, pulses(), 5'b00000); end
        end
        $display("test_reset_mid_wait: reset discards pending jump");
    endtask

    initial begin
        i_reset = 1'b0; i_hold = 1'b0;
        i_valid_id = 1'b0; i_instruccion = 32'h0; i_jump = 1'b0; i_return = 1'b0;
        i_rd_selector = 1'b0; i_pcjump = 32'h0; i_return_address = 32'h0;
        i_ex_regwrite = 1'b0; i_ex_rd = 5'd0; i_mem_memread = 1'b0; i_mem_rd = 5'd0;
        test_reset();
        test_j();
        test_jal();
        test_jalr_hazard();
        test_jr_timeout();
        test_rs_zero();
        test_hold();
        test_back_to_back();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_jump_ctrl

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Sequences the ID-stage jump unit (J, JAL, JR, JALR) against the pipeline.
- Detects a jump in ID and stalls JR/JALR until the rs register value is safe to read.
- Then issues a one-cycle PC redirect, flushes the two wrong-path instructions, and requests the link-register write.
- Sits between the jump unit, the PC register, the IF/ID and ID/EX latches, and the register-file write port.

Parameters:
DATA_WIDTH, 32, instruction/PC/data width
REG_ADDR, 5, register index width
MAX_WAIT, 4, maximum hazard-wait cycles before timeout
SIZEOP, 6, opcode/funct field width

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_hold  input  1  global pipeline hold; freezes the FSM
i_valid_id  input  1  ID holds a valid instruction
i_instruccion  input  DATA_WIDTH  ID instruction
i_jump  input  1  jump unit: jump detected
i_return  input  1  jump unit: link required
i_rd_selector  input  1  jump unit: 1 = link to r31, 0 = link to rd
i_pcjump  input  DATA_WIDTH  jump unit target
i_return_address  input  DATA_WIDTH  jump unit link value
i_ex_regwrite  input  1  EX instruction writes a register
i_ex_rd  input  REG_ADDR  EX destination
i_mem_memread  input  1  MEM instruction is a load
i_mem_rd  input  REG_ADDR  MEM load destination
o_pc_sel  output  1  PC loads o_pc_target
o_pc_target  output  DATA_WIDTH  registered jump target
o_stall  output  1  hold PC and IF/ID, bubble into ID/EX
o_flush_ifid  output  1  bubble into IF/ID
o_flush_idex  output  1  bubble into ID/EX
o_link_we  output  1  link write strobe
o_link_addr  output  REG_ADDR  link register index
o_link_data  output  DATA_WIDTH  link value
o_timeout  output  1  sticky: hazard wait exceeded MAX_WAIT

Behaviour:
- Reset (i_reset=0, async): state IDLE, wait counter 0; all outputs 0, including o_pc_target, o_link_addr, o_link_data and o_timeout.
- States: IDLE, WAIT, REDIRECT.
- Register jump: i_instruccion[31:26]==0 and funct in {001000, 001001}. rs = i_instruccion[25:21]; rd = i_instruccion[15:11].
- Hazard, combinational: register jump AND rs!=0 AND ((i_ex_regwrite AND i_ex_rd==rs) OR (i_mem_memread AND i_mem_rd==rs)).
- IDLE:
  - i_valid_id AND i_jump AND no hazard → REDIRECT.
  - Same cycle, register o_pc_target<=i_pcjump, o_link_data<=i_return_address, o_link_addr<=(i_rd_selector ? 31 : rd), link-pending<=i_return.
  - i_valid_id AND i_jump AND hazard → WAIT; counter<=1.
- WAIT:
  - o_stall=1 (combinational from state).
  - Hazard cleared → capture as in IDLE, go to REDIRECT.
  - Otherwise counter increments. At counter==MAX_WAIT, set o_timeout and capture/REDIRECT regardless.
- REDIRECT (exactly one cycle):
  - o_pc_sel=1, o_flush_ifid=1, o_flush_idex=1.
  - o_link_we = link-pending.
  - Next state IDLE.
  - i_valid_id/i_jump are ignored in this cycle (ID holds a wrong-path instruction).
- Latency: jump in ID at cycle N without hazard → redirect at N+1 → target fetched at N+2. Penalty is 2 bubbles; each hazard cycle adds 1.
- i_hold=1: state, counter and captured registers are frozen. o_pc_sel, o_flush_*, o_link_we are forced to 0. o_stall keeps its state value. Pulses resume when hold drops.
- Hazard and timeout in the same cycle: redirect is taken; o_timeout is set.
- rs==0 never hazards.
- Reset asserted mid-WAIT or mid-REDIRECT: immediate IDLE with no pulse; captured target discarded.
- o_timeout clears only on reset.

Optional Feature:
JUMP_CTRL_STATS_EN
- Defined: adds outputs o_jump_count[31:0] (increments on each REDIRECT cycle that is not held) and o_stall_count[31:0] (increments on each WAIT cycle that is not held). Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode/funct localparams: J=000010, JAL=000011, JR=001000, JALR=001001;
  - the link register index 31;
  - FSM state encoding IDLE=2'd0, WAIT=2'd1, REDIRECT=2'd2.
- One sub-module, jump_hazard_detect: the combinational hazard compare, reusable by a future branch controller.

Test Plan:
- J at PC 0x40 (target 0x100), no hazard → N+1: o_pc_sel=1, o_pc_target=0x100, both flushes 1, o_link_we=0; N+2: all pulses 0.
- JAL, i_return_address=0x42 → REDIRECT: o_link_we=1, o_link_addr=31, o_link_data=0x42.
- JALR rs=5, rd=7; EX writes r5 for 1 cycle → o_stall=1 for one cycle, then REDIRECT with o_link_addr=7 and target = i_pcjump sampled after the hazard cleared.
- JR rs=3 with MEM load to r3 held constant, MAX_WAIT=4 → 4 stall cycles, o_timeout=1, REDIRECT issued; o_timeout stays 1.
- i_hold=1 during REDIRECT for 3 cycles → no pulses while held; a single redirect pulse after release.
- i_reset low mid-WAIT → all outputs 0 immediately; no redirect after release; a jump present in ID during the REDIRECT cycle is ignored.
